// File: rtl/complex_mag_stream.sv
// rtl/complex_mag_stream.sv - pipelined I/Q magnitude stream with per-frame peak tracker
module complex_mag_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 10
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] s_i_in,
    input  logic [DATA_WIDTH-1:0] s_q_in,
    input  logic                  s_last_in,
    input  logic                  s_valid_in,
    output logic                  s_ready_out,
    input  logic [1:0]            mode_in,
    output logic [DATA_WIDTH:0]   m_mag_out,
    output logic                  m_last_out,
    output logic                  m_valid_out,
    input  logic                  m_ready_in,
    output logic [DATA_WIDTH:0]   peak_out,
    output logic [IDX_WIDTH-1:0]  peak_idx_out,
    output logic                  peak_valid_out
);

    localparam logic [DATA_WIDTH-1:0] ABS_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_WIDTH-1:0]  IDX_ONE = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

    // Two's-complement magnitude; the most negative value lands on 2**(DATA_WIDTH-1),
    // which is representable because the result is read as unsigned.
    function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] x);
        abs_val = x[DATA_WIDTH-1] ? (~x + ABS_ONE) : x;
    endfunction

    // Alpha-max-plus-beta-min family; one extra bit keeps max+min from wrapping.
    function automatic logic [DATA_WIDTH:0] combine(input logic [DATA_WIDTH-1:0] mx,
                                                    input logic [DATA_WIDTH-1:0] mn,
                                                    input logic [1:0]            mode);
        logic [DATA_WIDTH:0] mx_e;
        logic [DATA_WIDTH:0] mn_e;
        mx_e = {1'b0, mx};
        mn_e = {1'b0, mn};
        case (mode)
            2'd0:    combine = mx_e + (mn_e >> 2);
            2'd1:    combine = mx_e + (mn_e >> 2) + (mn_e >> 3);
            2'd2:    combine = mx_e + mn_e;
            default: combine = mx_e;
        endcase
    endfunction

    // Stage 1 (abs) registers
    logic                  v1_q, v1_d;
    logic [DATA_WIDTH-1:0] ai1_q, ai1_d;
    logic [DATA_WIDTH-1:0] aq1_q, aq1_d;
    logic [1:0]            mode1_q, mode1_d;
    logic                  last1_q, last1_d;

    // Stage 2 (min/max) registers
    logic                  v2_q, v2_d;
    logic [DATA_WIDTH-1:0] max2_q, max2_d;
    logic [DATA_WIDTH-1:0] min2_q, min2_d;
    logic [1:0]            mode2_q, mode2_d;
    logic                  last2_q, last2_d;

    // Stage 3 (combine) registers, drive the master side directly
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH:0]   m_mag_q, m_mag_d;
    logic                  m_last_q, m_last_d;

    // Peak tracker state
    logic [IDX_WIDTH-1:0]  idx_cnt_q, idx_cnt_d;
    logic                  first_q, first_d;
    logic [DATA_WIDTH:0]   run_peak_q, run_peak_d;
    logic [IDX_WIDTH-1:0]  run_idx_q, run_idx_d;
    logic [DATA_WIDTH:0]   peak_q, peak_d;
    logic [IDX_WIDTH-1:0]  peak_idx_q, peak_idx_d;
    logic                  peak_valid_q, peak_valid_d;

    logic en;
    logic out_hs;

    assign en          = !m_valid_q || m_ready_in;
    assign out_hs      = m_valid_q && m_ready_in;
    assign s_ready_out = en && !rst_in;

    assign m_valid_out    = m_valid_q;
    assign m_mag_out      = m_mag_q;
    assign m_last_out     = m_last_q;
    assign peak_out       = peak_q;
    assign peak_idx_out   = peak_idx_q;
    assign peak_valid_out = peak_valid_q;

    // Stage 1: capture the incoming beat as component magnitudes; hold when stalled
    always_comb begin
        v1_d    = v1_q;
        ai1_d   = ai1_q;
        aq1_d   = aq1_q;
        mode1_d = mode1_q;
        last1_d = last1_q;
        if (en) begin
            v1_d    = s_valid_in;
            ai1_d   = abs_val(s_i_in);
            aq1_d   = abs_val(s_q_in);
            mode1_d = mode_in;
            last1_d = s_last_in;
        end
    end

    // Stage 2: order the two magnitudes into max and min
    always_comb begin
        v2_d    = v2_q;
        max2_d  = max2_q;
        min2_d  = min2_q;
        mode2_d = mode2_q;
        last2_d = last2_q;
        if (en) begin
            v2_d    = v1_q;
            mode2_d = mode1_q;
            last2_d = last1_q;
            if (ai1_q >= aq1_q) begin
                max2_d = ai1_q;
                min2_d = aq1_q;
            end else begin
                max2_d = aq1_q;
                min2_d = ai1_q;
            end
        end
    end

    // Stage 3: apply the beat's own approximation mode
    always_comb begin
        m_valid_d = m_valid_q;
        m_mag_d   = m_mag_q;
        m_last_d  = m_last_q;
        if (en) begin
            m_valid_d = v2_q;
            m_mag_d   = combine(max2_q, min2_q, mode2_q);
            m_last_d  = last2_q;
        end
    end

    // Peak tracker: fold each delivered beat into the running peak, publish on TLAST
    always_comb begin
        logic                 take;
        logic [DATA_WIDTH:0]  nxt_peak;
        logic [IDX_WIDTH-1:0] nxt_idx;
        idx_cnt_d    = idx_cnt_q;
        first_d      = first_q;
        run_peak_d   = run_peak_q;
        run_idx_d    = run_idx_q;
        peak_d       = peak_q;
        peak_idx_d   = peak_idx_q;
        peak_valid_d = 1'b0;
        // Strictly-greater keeps the earliest index on ties; first beat always loads
        // even if the wrapped counter happens to be zero mid-frame.
        take     = first_q || (m_mag_q > run_peak_q);
        nxt_peak = take ? m_mag_q : run_peak_q;
        nxt_idx  = take ? idx_cnt_q : run_idx_q;
        if (out_hs) begin
            if (m_last_q) begin
                peak_d       = nxt_peak;
                peak_idx_d   = nxt_idx;
                peak_valid_d = 1'b1;
                idx_cnt_d    = '0;
                first_d      = 1'b1;
                run_peak_d   = '0;
                run_idx_d    = '0;
            end else begin
                run_peak_d = nxt_peak;
                run_idx_d  = nxt_idx;
                idx_cnt_d  = idx_cnt_q + IDX_ONE;
                first_d    = 1'b0;
            end
        end
    end

    // Pipeline registers; reset discards every in-flight beat
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v1_q      <= 1'b0;
            ai1_q     <= '0;
            aq1_q     <= '0;
            mode1_q   <= '0;
            last1_q   <= 1'b0;
            v2_q      <= 1'b0;
            max2_q    <= '0;
            min2_q    <= '0;
            mode2_q   <= '0;
            last2_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_mag_q   <= '0;
            m_last_q  <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            ai1_q     <= ai1_d;
            aq1_q     <= aq1_d;
            mode1_q   <= mode1_d;
            last1_q   <= last1_d;
            v2_q      <= v2_d;
            max2_q    <= max2_d;
            min2_q    <= min2_d;
            mode2_q   <= mode2_d;
            last2_q   <= last2_d;
            m_valid_q <= m_valid_d;
            m_mag_q   <= m_mag_d;
            m_last_q  <= m_last_d;
        end
    end

    // Peak tracker registers; reset drops any partial frame without a summary pulse
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_cnt_q    <= '0;
            first_q      <= 1'b1;
            run_peak_q   <= '0;
            run_idx_q    <= '0;
            peak_q       <= '0;
            peak_idx_q   <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            idx_cnt_q    <= idx_cnt_d;
            first_q      <= first_d;
            run_peak_q   <= run_peak_d;
            run_idx_q    <= run_idx_d;
            peak_q       <= peak_d;
            peak_idx_q   <= peak_idx_d;
            peak_valid_q <= peak_valid_d;
        end
    end

endmodule

// File: tb/tb_complex_mag_stream.sv
// tb/tb_complex_mag_stream.sv - directed self-checking bench for complex_mag_stream
module tb_complex_mag_stream;

    localparam int W  = 32;
    localparam int IW = 10;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [W-1:0]  s_i_in;
    logic [W-1:0]  s_q_in;
    logic          s_last_in;
    logic          s_valid_in;
    logic          s_ready_out;
    logic [1:0]    mode_in;
    logic [W:0]    m_mag_out;
    logic          m_last_out;
    logic          m_valid_out;
    logic          m_ready_in;
    logic [W:0]    peak_out;
    logic [IW-1:0] peak_idx_out;
    logic          peak_valid_out;

    complex_mag_stream #(.DATA_WIDTH(W), .IDX_WIDTH(IW)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .s_i_in         (s_i_in),
        .s_q_in         (s_q_in),
        .s_last_in      (s_last_in),
        .s_valid_in     (s_valid_in),
        .s_ready_out    (s_ready_out),
        .mode_in        (mode_in),
        .m_mag_out      (m_mag_out),
        .m_last_out     (m_last_out),
        .m_valid_out    (m_valid_out),
        .m_ready_in     (m_ready_in),
        .peak_out       (peak_out),
        .peak_idx_out   (peak_idx_out),
        .peak_valid_out (peak_valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [W-1:0] i;
        logic [W-1:0] q;
        logic         last;
        logic [1:0]   mode;
    } beat_t;

    int            n_cmp  = 0;
    int            n_fail = 0;
    beat_t         in_q[$];
    logic [W:0]    out_mag[$];
    logic          out_last[$];
    logic [W:0]    pk_val[$];
    logic [IW-1:0] pk_idx[$];
    int            last_hs_cyc;
    int            pk_cyc;
    bit [7:0]      ready_pat = 8'b0101_1001;

    function automatic beat_t mk(input int i, input int q, input bit last, input int mode);
        beat_t b;
        b.i    = i;
        b.q    = q;
        b.last = last;
        b.mode = mode[1:0];
        return b;
    endfunction

    task automatic drive(input bit v, input beat_t b, input bit rdy, input bit rst);
        @(negedge clk_in);
        rst_in     = rst;
        s_valid_in = v;
        s_i_in     = b.i;
        s_q_in     = b.q;
        s_last_in  = b.last;
        mode_in    = b.mode;
        m_ready_in = rdy;
        #1;
    endtask

    task automatic run(input bit use_pat);
        int         cyc;
        int         expect_n;
        bit         prev_stall;
        logic [W:0] prev_mag;
        logic       prev_last;
        beat_t      idle;
        cyc        = 0;
        expect_n   = in_q.size();
        prev_stall = 0;
        prev_mag   = '0;
        prev_last  = 0;
        idle       = mk(0, 0, 0, 0);
        last_hs_cyc = -1;
        pk_cyc      = -1;
        out_mag.delete();
        out_last.delete();
        pk_val.delete();
        pk_idx.delete();
        while ((in_q.size() > 0 || out_mag.size() < expect_n) && cyc < 300) begin
            if (in_q.size() > 0) drive(1, in_q[0], use_pat ? ready_pat[cyc % 8] : 1'b1, 0);
            else                 drive(0, idle, use_pat ? ready_pat[cyc % 8] : 1'b1, 0);
            if (prev_stall) begin
                n_cmp++;
                if (m_valid_out !== 1'b1 || m_mag_out !== prev_mag || m_last_out !== prev_last) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc=%0d: valid=%b mag=%0d last=%b, required valid=1 mag=%0d last=%b",
                             cyc, m_valid_out, m_mag_out, m_last_out, prev_mag, prev_last);
                end
            end
            if (m_valid_out && !m_ready_in) begin
                n_cmp++;
                if (s_ready_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL s_ready_in_stall cyc=%0d: s_ready_out=%b, required 0", cyc, s_ready_out);
                end
            end
            if (peak_valid_out) begin
                pk_val.push_back(peak_out);
                pk_idx.push_back(peak_idx_out);
                pk_cyc = cyc;
            end
            if (s_valid_in && s_ready_out) void'(in_q.pop_front());
            if (m_valid_out && m_ready_in) begin
                out_mag.push_back(m_mag_out);
                out_last.push_back(m_last_out);
                if (m_last_out) last_hs_cyc = cyc;
            end
            prev_stall = m_valid_out && !m_ready_in;
            prev_mag   = m_mag_out;
            prev_last  = m_last_out;
            cyc++;
        end
        n_cmp++;
        if (cyc >= 300) begin
            n_fail++;
            $display("FAIL run_timeout: got %0d beats, required %0d", out_mag.size(), expect_n);
            in_q.delete();
        end
        repeat (3) begin
            drive(0, idle, 1, 0);
            if (peak_valid_out) begin
                pk_val.push_back(peak_out);
                pk_idx.push_back(peak_idx_out);
                pk_cyc = cyc;
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        beat_t idle;
        idle = mk(0, 0, 0, 0);
        drive(0, idle, 1, 1);
        drive(0, idle, 1, 1);
        n_cmp++;
        if (m_valid_out !== 1'b0 || m_mag_out !== '0 || m_last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b mag=%0d last=%b, required 0 0 0", m_valid_out, m_mag_out, m_last_out);
        end
        n_cmp++;
        if (peak_out !== '0 || peak_idx_out !== '0 || peak_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_peak: peak=%0d idx=%0d pv=%b, required 0 0 0", peak_out, peak_idx_out, peak_valid_out);
        end
        n_cmp++;
        if (s_ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: s_ready_out=%b, required 0", s_ready_out);
        end
        drive(0, idle, 1, 0);
        n_cmp++;
        if (s_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: s_ready_out=%b, required 1", s_ready_out);
        end
    endtask

    task automatic test_modes();
        int         exp_m[4] = '{4, 4, 7, 4};
        logic [W:0] e;
        beat_t      idle;
        idle = mk(0, 0, 0, 0);
        for (int m = 0; m < 4; m++) begin
            e = exp_m[m];
            drive(1, mk(3, -4, 1, m), 1, 0);
            n_cmp++;
            if (s_ready_out !== 1'b1) begin
                n_fail++;
                $display("FAIL mode%0d_accept: s_ready_out=%b, required 1", m, s_ready_out);
            end
            for (int k = 1; k <= 3; k++) begin
                drive(0, idle, 1, 0);
                n_cmp++;
                if (k < 3 && m_valid_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mode%0d_early k=%0d: m_valid_out=%b, required 0", m, k, m_valid_out);
                end else if (k == 3 && (m_valid_out !== 1'b1 || m_mag_out !== e || m_last_out !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL mode%0d_mag: valid=%b mag=%0d last=%b, required 1 %0d 1",
                             m, m_valid_out, m_mag_out, m_last_out, e);
                end
            end
            drive(0, idle, 1, 0);
            n_cmp++;
            if (peak_valid_out !== 1'b1 || peak_out !== e || peak_idx_out !== '0) begin
                n_fail++;
                $display("FAIL mode%0d_single_peak: pv=%b peak=%0d idx=%0d, required 1 %0d 0",
                         m, peak_valid_out, peak_out, peak_idx_out, e);
            end
        end
    endtask

    task automatic test_most_negative();
        logic [W:0] e[2];
        e[0] = 33'h1_0000_0000;
        e[1] = 33'h0_A000_0000;
        in_q.push_back(mk(32'sh8000_0000, 32'sh8000_0000, 0, 2));
        in_q.push_back(mk(32'sh8000_0000, 32'sh8000_0000, 1, 0));
        run(0);
        n_cmp++;
        if (out_mag.size() !== 2) begin
            n_fail++;
            $display("FAIL most_neg_count: got %0d beats, required 2", out_mag.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (out_mag[k] !== e[k]) begin
                    n_fail++;
                    $display("FAIL most_neg_mag%0d: mag=%h, required %h", k, out_mag[k], e[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int         exp_mag[8] = '{10, 12, 10, 19, 7, 115, 1, 6};
        logic [W:0] e;
        for (int pass = 0; pass < 2; pass++) begin
            in_q.push_back(mk(10, 0, 0, 2));
            in_q.push_back(mk(-5, 12, 0, 3));
            in_q.push_back(mk(8, 8, 0, 0));
            in_q.push_back(mk(-16, -8, 0, 1));
            in_q.push_back(mk(0, -7, 0, 2));
            in_q.push_back(mk(100, -40, 0, 1));
            in_q.push_back(mk(1, 1, 0, 0));
            in_q.push_back(mk(-3, -3, 1, 2));
            run(pass[0]);
            n_cmp++;
            if (out_mag.size() !== 8) begin
                n_fail++;
                $display("FAIL bp%0d_count: got %0d beats, required 8", pass, out_mag.size());
            end else begin
                for (int k = 0; k < 8; k++) begin
                    e = exp_mag[k];
                    n_cmp++;
                    if (out_mag[k] !== e || out_last[k] !== (k == 7)) begin
                        n_fail++;
                        $display("FAIL bp%0d_beat%0d: mag=%0d last=%b, required %0d %b",
                                 pass, k, out_mag[k], out_last[k], e, (k == 7));
                    end
                end
            end
            n_cmp++;
            if (pk_val.size() !== 1) begin
                n_fail++;
                $display("FAIL bp%0d_peak_count: got %0d pulses, required 1", pass, pk_val.size());
            end else if (pk_val[0] !== 33'd115 || pk_idx[0] !== 10'd5) begin
                n_fail++;
                $display("FAIL bp%0d_peak: peak=%0d idx=%0d, required 115 5", pass, pk_val[0], pk_idx[0]);
            end
        end
    endtask

    task automatic test_peak();
        in_q.push_back(mk(5, 0, 0, 3));
        in_q.push_back(mk(9, 0, 0, 3));
        in_q.push_back(mk(2, 0, 0, 3));
        in_q.push_back(mk(-9, 0, 0, 3));
        in_q.push_back(mk(1, 0, 1, 3));
        run(0);
        n_cmp++;
        if (pk_val.size() !== 1) begin
            n_fail++;
            $display("FAIL peak_count: got %0d pulses, required 1", pk_val.size());
        end else if (pk_val[0] !== 33'd9 || pk_idx[0] !== 10'd1) begin
            n_fail++;
            $display("FAIL peak_value: peak=%0d idx=%0d, required 9 1", pk_val[0], pk_idx[0]);
        end
        n_cmp++;
        if (last_hs_cyc < 0 || pk_cyc !== last_hs_cyc + 1) begin
            n_fail++;
            $display("FAIL peak_timing: pulse cyc=%0d, required %0d", pk_cyc, last_hs_cyc + 1);
        end
    endtask

    task automatic test_mode_switch();
        int         exp_mag[5] = '{4, 4, 4, 7, 7};
        logic [W:0] e;
        in_q.push_back(mk(3, -4, 0, 0));
        in_q.push_back(mk(3, -4, 0, 0));
        in_q.push_back(mk(3, -4, 0, 0));
        in_q.push_back(mk(3, -4, 0, 2));
        in_q.push_back(mk(3, -4, 1, 2));
        run(0);
        n_cmp++;
        if (out_mag.size() !== 5) begin
            n_fail++;
            $display("FAIL switch_count: got %0d beats, required 5", out_mag.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                e = exp_mag[k];
                n_cmp++;
                if (out_mag[k] !== e) begin
                    n_fail++;
                    $display("FAIL switch_beat%0d: mag=%0d, required %0d", k, out_mag[k], e);
                end
            end
        end
        n_cmp++;
        if (pk_val.size() !== 1 || pk_val[0] !== 33'd7 || pk_idx[0] !== 10'd3) begin
            n_fail++;
            $display("FAIL switch_peak: pulses=%0d, required 1 pulse with peak 7 idx 3", pk_val.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        beat_t idle;
        idle = mk(0, 0, 0, 0);
        drive(1, mk(50, 0, 0, 3), 1, 0);
        drive(1, mk(1, 0, 0, 3), 1, 0);
        drive(1, mk(2, 0, 0, 3), 1, 0);
        drive(1, mk(3, 0, 0, 3), 1, 0);
        drive(0, idle, 1, 1);
        n_cmp++;
        if (s_ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ready: s_ready_out=%b, required 0", s_ready_out);
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, idle, 1, 0);
            n_cmp++;
            if (m_valid_out !== 1'b0 || peak_valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_quiet k=%0d: valid=%b pv=%b, required 0 0", k, m_valid_out, peak_valid_out);
            end
        end
        in_q.push_back(mk(8, 0, 0, 3));
        in_q.push_back(mk(4, 0, 0, 3));
        in_q.push_back(mk(2, 0, 1, 3));
        run(0);
        n_cmp++;
        if (pk_val.size() !== 1 || pk_val[0] !== 33'd8 || pk_idx[0] !== 10'd0) begin
            n_fail++;
            $display("FAIL mid_reset_next_peak: pulses=%0d, required 1 pulse with peak 8 idx 0", pk_val.size());
        end
    endtask

    initial begin
        rst_in     = 1'b1;
        s_valid_in = 1'b0;
        s_i_in     = '0;
        s_q_in     = '0;
        s_last_in  = 1'b0;
        mode_in    = '0;
        m_ready_in = 1'b1;
        test_reset();
        test_modes();
        test_most_negative();
        test_backpressure();
        test_peak();
        test_mode_switch();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
